ctrl_pipe: RTL and testbench
============================

# ctrl_pipe

Carries decoded control signals from the ID stage through the ID/EX, EX/MEM and MEM/WB pipeline registers, so that each stage sees the control word of the instruction it is executing. It sits directly downstream of the control unit and consumes all nine of its outputs. It inserts bubbles on stall (load-use) and flush (taken branch/jump), and counts the bubbles it inserts.

## Interface
- `CNT_W`, 16: width of the bubble counter.
- `clk` in 1: single clock, rising edge.
- `arst` in 1: asynchronous, active-high reset.
- `id_alu_op` in 2, `id_reg_dst`, `id_branch`, `id_mem_read`, `id_mem_2_reg`, `id_mem_write`, `id_alu_src`, `id_reg_write`, `id_jump` in 1 each: control word from the control unit.
- `stall` in 1: load-use hazard; inject a bubble into EX.
- `flush` in 1: taken branch/jump resolved in MEM; kill the EX and MEM entries.
- `ex_alu_op` out 2, `ex_reg_dst`, `ex_alu_src`, `ex_mem_read` out 1: EX-stage controls. `ex_mem_read` feeds the hazard unit.
- `mem_branch`, `mem_jump`, `mem_mem_read`, `mem_mem_write` out 1: MEM-stage controls.
- `wb_mem_2_reg`, `wb_reg_write` out 1: WB-stage controls.
- `ex_valid`, `mem_valid`, `wb_valid` out 1: the stage holds a real instruction, not a bubble.
- `bubble_cnt` out CNT_W: saturating count of inserted bubbles.

## Operation
- Three stage registers: EX holds the full 10-bit control word; MEM holds branch, jump, mem_read, mem_write, mem_2_reg and reg_write; WB holds mem_2_reg and reg_write. Each stage also has a valid bit.
- Bubble: all stored bits are 0, including alu_op = 2'd0, and valid is 0.
- Priority per edge is arst > flush > stall > advance.
- Advance: EX ← ID word with valid=1; MEM ← EX; WB ← MEM.
- Stall only: EX ← bubble; MEM ← EX; WB ← MEM. The ID input is not captured, because upstream holds it.
- Flush (with or without stall): EX ← bubble; MEM ← bubble; WB ← MEM. The instruction in MEM, which is the branch itself, still retires.
- WB always advances from MEM; nothing can hold it.
- Counter increments on each edge where stall or flush is asserted: +1 for stall only, +2 for flush (two slots killed). It saturates at 2^CNT_W−1 with no wrap.
- Mid-operation arst: all stages become bubbles immediately; the counter clears.

## Timing
- Latency from ID input to EX output is 1 cycle, to MEM 2 cycles, to WB 3 cycles.
- Outputs are driven directly from the stage registers, with no combinational path from inputs to outputs.
- `stall` and `flush` are sampled on the same edge as the ID word.
- The reset value of every output is 0: all controls, all valids, and `bubble_cnt`.
- The first edge after arst deasserts captures the ID word normally.

## Configuration
- `CTRL_PIPE_XCLEAN_EN` defined: each ID input bit that is not 0/1 (x/z) is replaced by 0 before capture. The control unit drives don't-cares for beq/j/sw, and this keeps the stage registers X-free in simulation.
- Not defined: inputs are captured as-is; x propagates, and synthesis results are identical.

## Structure
- Shared package/header `ctrl_pkg`:
  - ALU op encodings: ADD=2'd0, SUB=2'd1, R_TYPE=2'd2.
  - Bubble constants per stage.
  - Stage word widths: EX=10, MEM=6, WB=2.
- One sub-module, `ctrl_stage_reg`: a parameterised-width register with async reset, bubble-load and valid. It is instantiated three times.

## Test plan
- R-type word (alu_op=2, reg_dst=1, reg_write=1) at cycle 0:
  - cycle 1: ex_alu_op=2, ex_reg_dst=1.
  - cycle 3: wb_reg_write=1, wb_valid=1.
- lw followed by stall for 1 cycle:
  - ex_mem_read=1, then ex_valid=0 on the next cycle.
  - mem_mem_read=1 continues.
  - bubble_cnt=1.
- beq in MEM (mem_branch=1) with flush=1:
  - next cycle: ex_valid=0, mem_valid=0, wb_valid=1 (beq retires).
  - bubble_cnt=2.
- flush and stall together on one edge: same result as flush only; bubble_cnt increments by 2, not 3.
- arst pulse mid-stream with all valids=1: all outputs 0 asynchronously, before the next clk edge; bubble_cnt=0.
- CNT_W=2:
  - stall held for 5 cycles: bubble_cnt=3, holds at 3.
  - with `CTRL_PIPE_XCLEAN_EN`, a jump word with reg_dst=x gives ex_reg_dst=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared control-word layouts, ALU op encodings and bubble constants for ctrl_pipe
package ctrl_pkg;
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_R_TYPE = 2'd2;
  localparam int EX_W = 10;
  localparam int MEM_W = 6;
  localparam int WB_W = 2;
  typedef struct packed {
    logic [1:0] alu_op;
    logic reg_dst;
    logic branch;
    logic mem_read;
    logic mem_2_reg;
    logic mem_write;
    logic alu_src;
    logic reg_write;
    logic jump;
  } ex_word_t;
  typedef struct packed {
    logic branch;
    logic jump;
    logic mem_read;
    logic mem_write;
    logic mem_2_reg;
    logic reg_write;
  } mem_word_t;
  typedef struct packed {
    logic mem_2_reg;
    logic reg_write;
  } wb_word_t;
  localparam ex_word_t EX_BUBBLE = '0;
  localparam mem_word_t MEM_BUBBLE = '0;
  localparam wb_word_t WB_BUBBLE = '0;
  // Maps every non-1 bit (0, x, z) to 0 so don't-care control bits never reach the registers.
  function automatic ex_word_t xclean(input ex_word_t w);
    ex_word_t r;
    for (int i = 0; i < EX_W; i++) r[i] = (w[i] === 1'b1);
    return r;
  endfunction
endpackage

// File: rtl/ctrl_stage_reg.sv
// ctrl_stage_reg: one pipeline stage register with async reset, bubble-load and valid bit
module ctrl_stage_reg #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         bubble,
  input  logic [W-1:0] d,
  input  logic         d_valid,
  output logic [W-1:0] q,
  output logic         valid
);
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      q <= '0;
      valid <= 1'b0;
    end else begin
      q <= bubble ? '0 : d;
      valid <= !bubble && d_valid;
    end
  end
endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: ID/EX, EX/MEM, MEM/WB control pipeline with stall/flush bubbles and a saturating bubble counter.
// Define CTRL_PIPE_XCLEAN_EN to force x/z control bits from the control unit to 0 before capture.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [1:0]       id_alu_op,
  input  logic             id_reg_dst,
  input  logic             id_branch,
  input  logic             id_mem_read,
  input  logic             id_mem_2_reg,
  input  logic             id_mem_write,
  input  logic             id_alu_src,
  input  logic             id_reg_write,
  input  logic             id_jump,
  input  logic             stall,
  input  logic             flush,
  output logic [1:0]       ex_alu_op,
  output logic             ex_reg_dst,
  output logic             ex_alu_src,
  output logic             ex_mem_read,
  output logic             mem_branch,
  output logic             mem_jump,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic             wb_mem_2_reg,
  output logic             wb_reg_write,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic [CNT_W-1:0] bubble_cnt
);
  ex_word_t id_raw, id_word, ex_q;
  mem_word_t mem_d, mem_q;
  wb_word_t wb_d, wb_q;
  logic [CNT_W:0] inc, cnt_sum;
  assign id_raw = '{id_alu_op, id_reg_dst, id_branch, id_mem_read, id_mem_2_reg,
                    id_mem_write, id_alu_src, id_reg_write, id_jump};
`ifdef CTRL_PIPE_XCLEAN_EN
  assign id_word = xclean(id_raw);
`else
  assign id_word = id_raw;
`endif
  assign mem_d = '{ex_q.branch, ex_q.jump, ex_q.mem_read, ex_q.mem_write, ex_q.mem_2_reg, ex_q.reg_write};
  assign wb_d = '{mem_q.mem_2_reg, mem_q.reg_write};
  ctrl_stage_reg #(.W(EX_W)) u_ex (
    .clk(clk), .arst(arst), .bubble(stall || flush),
    .d(id_word), .d_valid(1'b1), .q(ex_q), .valid(ex_valid)
  );
  ctrl_stage_reg #(.W(MEM_W)) u_mem (
    .clk(clk), .arst(arst), .bubble(flush),
    .d(mem_d), .d_valid(ex_valid), .q(mem_q), .valid(mem_valid)
  );
  // WB is never bubbled: the branch sitting in MEM during a flush still retires.
  ctrl_stage_reg #(.W(WB_W)) u_wb (
    .clk(clk), .arst(arst), .bubble(1'b0),
    .d(wb_d), .d_valid(mem_valid), .q(wb_q), .valid(wb_valid)
  );
  // A flush kills two slots (EX and MEM) whether or not stall is also raised.
  assign inc = flush ? (CNT_W+1)'(2) : {{CNT_W{1'b0}}, stall};
  assign cnt_sum = {1'b0, bubble_cnt} + inc;
  always_ff @(posedge clk or posedge arst) begin
    if (arst) bubble_cnt <= '0;
    else bubble_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end
  assign ex_alu_op = ex_q.alu_op;
  assign ex_reg_dst = ex_q.reg_dst;
  assign ex_alu_src = ex_q.alu_src;
  assign ex_mem_read = ex_q.mem_read;
  assign mem_branch = mem_q.branch;
  assign mem_jump = mem_q.jump;
  assign mem_mem_read = mem_q.mem_read;
  assign mem_mem_write = mem_q.mem_write;
  assign wb_mem_2_reg = wb_q.mem_2_reg;
  assign wb_reg_write = wb_q.reg_write;
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed-vector bench for ctrl_pipe (16-bit and 2-bit counter instances share stimulus)
module tb_ctrl_pipe;
  logic clk = 1'b0;
  logic arst = 1'b1;
  logic stall = 1'b0;
  logic flush = 1'b0;
  logic [9:0] id_w = '0;
  logic [1:0] id_alu_op;
  logic id_reg_dst, id_branch, id_mem_read, id_mem_2_reg, id_mem_write, id_alu_src, id_reg_write, id_jump;
  logic [1:0] ex_alu_op, s_ex_alu_op;
  logic ex_reg_dst, ex_alu_src, ex_mem_read, mem_branch, mem_jump, mem_mem_read, mem_mem_write;
  logic wb_mem_2_reg, wb_reg_write, ex_valid, mem_valid, wb_valid;
  logic s_ex_reg_dst, s_ex_alu_src, s_ex_mem_read, s_mem_branch, s_mem_jump, s_mem_mem_read, s_mem_mem_write;
  logic s_wb_mem_2_reg, s_wb_reg_write, s_ex_valid, s_mem_valid, s_wb_valid;
  logic [15:0] bubble_cnt;
  logic [1:0] s_bubble_cnt;
  int checks = 0;
  int errors = 0;
  // word layout: {alu_op[1:0], reg_dst, branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write, jump}
  localparam logic [9:0] W_RTYPE = 10'b10_1000_0010;
  localparam logic [9:0] W_LW = 10'b00_0011_0110;
  localparam logic [9:0] W_BEQ = 10'b01_0100_0000;
  assign {id_alu_op, id_reg_dst, id_branch, id_mem_read, id_mem_2_reg,
          id_mem_write, id_alu_src, id_reg_write, id_jump} = id_w;
  always #5 clk = ~clk;
  ctrl_pipe u_dut (
    .clk(clk), .arst(arst), .id_alu_op(id_alu_op), .id_reg_dst(id_reg_dst), .id_branch(id_branch),
    .id_mem_read(id_mem_read), .id_mem_2_reg(id_mem_2_reg), .id_mem_write(id_mem_write),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_jump(id_jump), .stall(stall), .flush(flush),
    .ex_alu_op(ex_alu_op), .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
    .mem_branch(mem_branch), .mem_jump(mem_jump), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .wb_mem_2_reg(wb_mem_2_reg), .wb_reg_write(wb_reg_write), .ex_valid(ex_valid), .mem_valid(mem_valid),
    .wb_valid(wb_valid), .bubble_cnt(bubble_cnt)
  );
  ctrl_pipe #(.CNT_W(2)) u_sat (
    .clk(clk), .arst(arst), .id_alu_op(id_alu_op), .id_reg_dst(id_reg_dst), .id_branch(id_branch),
    .id_mem_read(id_mem_read), .id_mem_2_reg(id_mem_2_reg), .id_mem_write(id_mem_write),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_jump(id_jump), .stall(stall), .flush(flush),
    .ex_alu_op(s_ex_alu_op), .ex_reg_dst(s_ex_reg_dst), .ex_alu_src(s_ex_alu_src), .ex_mem_read(s_ex_mem_read),
    .mem_branch(s_mem_branch), .mem_jump(s_mem_jump), .mem_mem_read(s_mem_mem_read), .mem_mem_write(s_mem_mem_write),
    .wb_mem_2_reg(s_wb_mem_2_reg), .wb_reg_write(s_wb_reg_write), .ex_valid(s_ex_valid), .mem_valid(s_mem_valid),
    .wb_valid(s_wb_valid), .bubble_cnt(s_bubble_cnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [14:0] outs();
    return {ex_alu_op, ex_reg_dst, ex_alu_src, ex_mem_read, mem_branch, mem_jump, mem_mem_read,
            mem_mem_write, wb_mem_2_reg, wb_reg_write, ex_valid, mem_valid, wb_valid};
  endfunction
  initial begin
    #12;
    check("reset_outs", 32'(outs()), 0);
    check("reset_cnt", 32'(bubble_cnt), 0);
    arst = 1'b0;
    id_w = W_RTYPE;
    step();
    check("rtype_ex_alu_op", 32'(ex_alu_op), 2);
    check("rtype_ex_reg_dst", 32'(ex_reg_dst), 1);
    check("rtype_ex_valid", 32'(ex_valid), 1);
    id_w = '0;
    step();
    check("rtype_mem_valid", 32'(mem_valid), 1);
    step();
    check("rtype_wb_reg_write", 32'(wb_reg_write), 1);
    check("rtype_wb_valid", 32'(wb_valid), 1);
    id_w = W_LW;
    step();
    check("lw_ex_mem_read", 32'(ex_mem_read), 1);
    check("lw_ex_alu_src", 32'(ex_alu_src), 1);
    id_w = W_RTYPE;
    stall = 1'b1;
    step();
    stall = 1'b0;
    check("stall_ex_valid", 32'(ex_valid), 0);
    check("stall_ex_mem_read", 32'(ex_mem_read), 0);
    check("stall_mem_mem_read", 32'(mem_mem_read), 1);
    check("stall_mem_valid", 32'(mem_valid), 1);
    check("stall_cnt", 32'(bubble_cnt), 1);
    check("stall_sat_cnt", 32'(s_bubble_cnt), 1);
    step();
    check("after_stall_ex", 32'({ex_valid, ex_alu_op}), 32'b110);
    check("after_stall_mem_valid", 32'(mem_valid), 0);
    check("after_stall_wb", 32'({wb_valid, wb_mem_2_reg, wb_reg_write}), 32'b111);
    id_w = W_BEQ;
    step();
    check("beq_ex_alu_op", 32'(ex_alu_op), 1);
    id_w = W_RTYPE;
    step();
    check("beq_mem_branch", 32'(mem_branch), 1);
    check("beq_mem_valid", 32'(mem_valid), 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_valids", 32'({ex_valid, mem_valid, wb_valid}), 32'b001);
    check("flush_mem_branch", 32'(mem_branch), 0);
    check("flush_wb_reg_write", 32'(wb_reg_write), 0);
    check("flush_cnt", 32'(bubble_cnt), 3);
    check("flush_sat_cnt", 32'(s_bubble_cnt), 3);
    step();
    step();
    check("refill_valids", 32'({ex_valid, mem_valid}), 32'b11);
    flush = 1'b1;
    stall = 1'b1;
    step();
    flush = 1'b0;
    stall = 1'b0;
    check("flush_stall_valids", 32'({ex_valid, mem_valid, wb_valid}), 32'b001);
    check("flush_stall_wb_reg_write", 32'(wb_reg_write), 1);
    check("flush_stall_cnt", 32'(bubble_cnt), 5);
    check("flush_stall_sat_cnt", 32'(s_bubble_cnt), 3);
    step();
    step();
    step();
    check("full_valids", 32'({ex_valid, mem_valid, wb_valid}), 32'b111);
    #2 arst = 1'b1;
    #1;
    check("arst_outs", 32'(outs()), 0);
    check("arst_cnt", 32'(bubble_cnt), 0);
    check("arst_sat_cnt", 32'(s_bubble_cnt), 0);
    arst = 1'b0;
    step();
    check("post_arst_ex", 32'({ex_valid, ex_alu_op, ex_reg_dst}), 32'b1101);
    check("post_arst_mem_valid", 32'(mem_valid), 0);
    stall = 1'b1;
    step();
    step();
    check("sat_cnt_2", 32'(s_bubble_cnt), 2);
    step();
    check("sat_cnt_3", 32'(s_bubble_cnt), 3);
    step();
    step();
    stall = 1'b0;
    check("sat_cnt_hold", 32'(s_bubble_cnt), 3);
    check("wide_cnt_5", 32'(bubble_cnt), 5);
`ifdef CTRL_PIPE_XCLEAN_EN
    id_w = 10'b00_x000_0001;
    step();
    check("xclean_ex_reg_dst", 32'(ex_reg_dst), 0);
    check("xclean_ex_valid", 32'(ex_valid), 1);
    step();
    check("xclean_mem_jump", 32'(mem_jump), 1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
